// File: rtl/cnn_pkg.sv
// Kernel geometry and window indexing that the window generator and conv kernel share.
// Window element (r,c) sits at flat index r*KERNEL_SIZE+c, with r=0 the oldest row.
package cnn_pkg;

   localparam int KERNEL_SIZE    = 5;
   localparam int KERNEL_AREA    = KERNEL_SIZE * KERNEL_SIZE;
   localparam int NUM_LB         = KERNEL_SIZE - 1;
   localparam int DATA_WIDTH_DEF = 16;

   function automatic int win_idx(input int r, input int c);
      return r * KERNEL_SIZE + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_5x5_if.sv
// Pixel-in / window-out valid-ready bundle. The testbench or an upstream block uses the master side.
// The window generator uses the slave side.
interface conv_window_gen_5x5_if #(
   parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH_DEF
);
   logic [DATA_WIDTH-1:0]                       pix_in;
   logic                                        pix_valid;
   logic                                        pix_ready;
   logic [cnn_pkg::KERNEL_AREA*DATA_WIDTH-1:0]  data_25P;
   logic                                        win_valid;
   logic                                        win_ready;
   logic                                        frame_done;

   modport master (
      output pix_in, pix_valid, win_ready,
      input  pix_ready, data_25P, win_valid, frame_done
   );

   modport slave (
      input  pix_in, pix_valid, win_ready,
      output pix_ready, data_25P, win_valid, frame_done
   );
endinterface

// File: rtl/conv_line_buf.sv
// One image row of storage: combinational read at addr_i, write on the clock when we_i is set.
// The contents are not reset, because the row/col gating upstream masks any stale data.
module conv_line_buf #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 28,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [AW-1:0]         addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end
endmodule

// File: rtl/conv_window_gen_5x5.sv
// Raster pixel stream to stride-1 5x5 windows. A window is valid one cycle after an accept with row>=4 and col>=4.
// pix_ready drops only while a window is held and win_ready is low; window data and state are then frozen.
module conv_window_gen_5x5
   import cnn_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28
) (
   input logic                  clk,
   input logic                  rst,
   conv_window_gen_5x5_if.slave stream_if
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int WW = KERNEL_AREA * DATA_WIDTH;

   logic [CW-1:0]         col_q, col_d;
   logic [RW-1:0]         row_q, row_d;
   logic [WW-1:0]         win_q, win_d;
   logic                  win_valid_q, win_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic [DATA_WIDTH-1:0] lb_rd [NUM_LB];
   logic [DATA_WIDTH-1:0] lb_wr [NUM_LB];
   logic                  pix_ready;
   logic                  accept;
   logic                  last_col;
   logic                  last_row;
   logic                  load;

   assign pix_ready = !win_valid_q || stream_if.win_ready;
   assign accept    = stream_if.pix_valid && pix_ready;
   assign last_col  = (col_q == CW'(IMG_W - 1));
   assign last_row  = (row_q == RW'(IMG_H - 1));
   assign load      = accept && (row_q >= RW'(KERNEL_SIZE - 1)) && (col_q >= CW'(KERNEL_SIZE - 1));

   // The rows cascade: each buffer takes the value the younger buffer held at this column.
   always_comb begin
      lb_wr[0] = stream_if.pix_in;
      for (int i = 1; i < NUM_LB; i++) begin
         lb_wr[i] = lb_rd[i-1];
      end
   end

   for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
      conv_line_buf #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (IMG_W)
      ) u_lb (
         .clk     (clk),
         .we_i    (accept),
         .addr_i  (col_q),
         .wdata_i (lb_wr[i]),
         .rdata_o (lb_rd[i])
      );
   end

   always_comb begin
      win_d = win_q;
      if (accept) begin
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
               win_d[win_idx(r, c)*DATA_WIDTH +: DATA_WIDTH] =
                  win_q[win_idx(r, c + 1)*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         // The oldest line buffer feeds the top row of the new right-hand column.
         for (int r = 0; r < NUM_LB; r++) begin
            win_d[win_idx(r, KERNEL_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = lb_rd[NUM_LB - 1 - r];
         end
         win_d[win_idx(KERNEL_SIZE - 1, KERNEL_SIZE - 1)*DATA_WIDTH +: DATA_WIDTH] = stream_if.pix_in;
      end
   end

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      if (accept) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
            frame_done_d = last_row;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
      if (load) begin
         win_valid_d = 1'b1;
      end else if (stream_if.win_ready) begin
         win_valid_d = 1'b0;
      end else begin
         win_valid_d = win_valid_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q        <= '0;
         row_q        <= '0;
         win_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign stream_if.pix_ready  = pix_ready;
   assign stream_if.data_25P   = win_q;
   assign stream_if.win_valid  = win_valid_q;
   assign stream_if.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv_window_gen_5x5.sv
// Scenario bench for conv_window_gen_5x5 with a scoreboard of expected windows built from the pixels it sends.
module tb_conv_window_gen_5x5;
   localparam int DW   = 16;
   localparam int W    = 28;
   localparam int H    = 28;
   localparam int AREA = 25;
   typedef logic [AREA*DW-1:0] win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_window_gen_5x5_if #(.DATA_WIDTH(DW)) vif();

   conv_window_gen_5x5 #(
      .DATA_WIDTH (DW),
      .IMG_W      (W),
      .IMG_H      (H)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .stream_if (vif)
   );

   int   tests  = 0;
   int   fails  = 0;
   int   fd_cnt = 0;
   win_t exp_q [$];
   win_t got_q [$];
   win_t ref_q [$];
   logic [DW-1:0] img [H][W];
   int   mrow = 0;
   int   mcol = 0;
   logic wv_m = 1'b0;
   logic fd_pend = 1'b0;

   function automatic logic [DW-1:0] elem(input win_t w, input int k);
      return w[k*DW +: DW];
   endfunction

   function automatic int first_diff();
      if (got_q.size() != ref_q.size()) return 0;
      for (int i = 0; i < got_q.size(); i++) begin
         if (got_q[i] !== ref_q[i]) return i;
      end
      return -1;
   endfunction

   // Behavioural model and scoreboard, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            mrow = 0; mcol = 0; wv_m = 1'b0; fd_pend = 1'b0;
         end else begin
            logic acc;
            logic load;
            win_t w;
            tests++;
            if (vif.win_valid !== wv_m) begin
               fails++;
               $display("FAIL win_valid at %0t: got %b, required %b", $time, vif.win_valid, wv_m);
            end
            tests++;
            if (vif.pix_ready !== (!wv_m || vif.win_ready)) begin
               fails++;
               $display("FAIL pix_ready at %0t: got %b, required %b", $time, vif.pix_ready, (!wv_m || vif.win_ready));
            end
            tests++;
            if (vif.frame_done !== fd_pend) begin
               fails++;
               $display("FAIL frame_done at %0t: got %b, required %b", $time, vif.frame_done, fd_pend);
            end
            if (vif.frame_done === 1'b1) fd_cnt++;
            if (vif.win_valid === 1'b1 && vif.win_ready === 1'b1) begin
               got_q.push_back(vif.data_25P);
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL window_unexpected at %0t: got %h, required none", $time, vif.data_25P);
               end else begin
                  w = exp_q.pop_front();
                  if (vif.data_25P !== w) begin
                     fails++;
                     $display("FAIL window_data at %0t: got %h, required %h", $time, vif.data_25P, w);
                  end
               end
            end
            acc  = vif.pix_valid && vif.pix_ready;
            load = 1'b0;
            fd_pend = 1'b0;
            if (acc) begin
               img[mrow][mcol] = vif.pix_in;
               if (mrow >= 4 && mcol >= 4) begin
                  for (int r = 0; r < 5; r++)
                     for (int c = 0; c < 5; c++)
                        w[(r*5+c)*DW +: DW] = img[mrow-4+r][mcol-4+c];
                  exp_q.push_back(w);
                  load = 1'b1;
               end
               fd_pend = (mrow == H-1 && mcol == W-1);
               if (mcol == W-1) begin
                  mcol = 0;
                  mrow = (mrow == H-1) ? 0 : mrow + 1;
               end else begin
                  mcol++;
               end
            end
            wv_m = load ? 1'b1 : ((wv_m && vif.win_ready) ? 1'b0 : wv_m);
         end
      end
   end

   task automatic send_pixels(input int first, input int last, input int gap_pct);
      for (int v = first; v <= last; v++) begin
         int guard;
         guard = 0;
         while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
            vif.pix_valid = 1'b0;
            vif.pix_in    = DW'($urandom);
            @(posedge clk); #1;
         end
         vif.pix_valid = 1'b1;
         vif.pix_in    = DW'(v);
         @(negedge clk);
         while (vif.pix_ready !== 1'b1 && guard < 200) begin
            guard++;
            @(negedge clk);
         end
         if (guard >= 200) begin
            tests++; fails++;
            $display("FAIL pix_ready_timeout pixel %0d: got %b, required 1", v, vif.pix_ready);
            vif.pix_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      vif.pix_valid = 1'b0;
   endtask

   task automatic drain();
      vif.pix_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tests++; if (vif.pix_ready !== 1'b1) begin fails++; $display("FAIL reset_pix_ready: got %b, required 1", vif.pix_ready); end
      tests++; if (vif.win_valid !== 1'b0) begin fails++; $display("FAIL reset_win_valid: got %b, required 0", vif.win_valid); end
      tests++; if (vif.frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b, required 0", vif.frame_done); end
      tests++; if (vif.data_25P !== '0) begin fails++; $display("FAIL reset_data: got %h, required 0", vif.data_25P); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_ramp();
      got_q.delete(); fd_cnt = 0;
      vif.win_ready = 1'b1;
      send_pixels(0, W*H-1, 0);
      drain();
      tests++; if (got_q.size() != 576) begin fails++; $display("FAIL ramp_count: got %0d, required 576", got_q.size()); end
      if (got_q.size() >= 26) begin
         tests++; if (elem(got_q[0], 0)  !== 16'd0)   begin fails++; $display("FAIL ramp_w0_e0: got %0d, required 0", elem(got_q[0], 0)); end
         tests++; if (elem(got_q[0], 24) !== 16'd116) begin fails++; $display("FAIL ramp_w0_e24: got %0d, required 116", elem(got_q[0], 24)); end
         tests++; if (elem(got_q[0], 4)  !== 16'd4)   begin fails++; $display("FAIL ramp_w0_e4: got %0d, required 4", elem(got_q[0], 4)); end
         tests++; if (elem(got_q[0], 20) !== 16'd112) begin fails++; $display("FAIL ramp_w0_e20: got %0d, required 112", elem(got_q[0], 20)); end
         tests++; if (elem(got_q[23], 0) !== 16'd23)  begin fails++; $display("FAIL row_end_w23_e0: got %0d, required 23", elem(got_q[23], 0)); end
         tests++; if (elem(got_q[24], 0) !== 16'd28)  begin fails++; $display("FAIL row_wrap_w24_e0: got %0d, required 28", elem(got_q[24], 0)); end
         tests++; if (elem(got_q[25], 0) !== 16'd29)  begin fails++; $display("FAIL row_wrap_w25_e0: got %0d, required 29", elem(got_q[25], 0)); end
      end
      tests++; if (fd_cnt != 1) begin fails++; $display("FAIL ramp_frame_done_count: got %0d, required 1", fd_cnt); end
      tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL ramp_pending: got %0d, required 0", exp_q.size()); end
      ref_q = got_q;
   endtask

   task automatic test_backpressure();
      win_t held;
      int   d;
      got_q.delete(); fd_cnt = 0;
      vif.win_ready = 1'b1;
      send_pixels(0, 399, 0);
      vif.win_ready = 1'b0;
      vif.pix_valid = 1'b1;
      vif.pix_in    = DW'(400);
      held = (exp_q.size() > 0) ? exp_q[0] : '0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++; if (vif.pix_ready !== 1'b0) begin fails++; $display("FAIL bp_pix_ready cycle %0d: got %b, required 0", i, vif.pix_ready); end
         tests++; if (vif.win_valid !== 1'b1) begin fails++; $display("FAIL bp_win_valid cycle %0d: got %b, required 1", i, vif.win_valid); end
         tests++; if (vif.data_25P !== held) begin fails++; $display("FAIL bp_data cycle %0d: got %h, required %h", i, vif.data_25P, held); end
      end
      @(posedge clk); #1;
      vif.win_ready = 1'b1;
      send_pixels(400, W*H-1, 0);
      drain();
      d = first_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL bp_sequence: got first difference at window %0d of %0d, required none", d, got_q.size()); end
      tests++; if (fd_cnt != 1) begin fails++; $display("FAIL bp_frame_done_count: got %0d, required 1", fd_cnt); end
   endtask

   task automatic test_gaps();
      int d;
      got_q.delete(); fd_cnt = 0;
      vif.win_ready = 1'b1;
      send_pixels(0, W*H-1, 50);
      drain();
      d = first_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL gap_sequence: got first difference at window %0d of %0d, required none", d, got_q.size()); end
      tests++; if (fd_cnt != 1) begin fails++; $display("FAIL gap_frame_done_count: got %0d, required 1", fd_cnt); end
   endtask

   task automatic test_back_to_back();
      got_q.delete(); fd_cnt = 0;
      vif.win_ready = 1'b1;
      send_pixels(0, 2*W*H-1, 0);
      drain();
      tests++; if (got_q.size() != 1152) begin fails++; $display("FAIL b2b_count: got %0d, required 1152", got_q.size()); end
      if (got_q.size() > 576) begin
         tests++; if (elem(got_q[576], 0)  !== 16'd784) begin fails++; $display("FAIL b2b_f2_e0: got %0d, required 784", elem(got_q[576], 0)); end
         tests++; if (elem(got_q[576], 24) !== 16'd900) begin fails++; $display("FAIL b2b_f2_e24: got %0d, required 900", elem(got_q[576], 24)); end
      end
      tests++; if (fd_cnt != 2) begin fails++; $display("FAIL b2b_frame_done_count: got %0d, required 2", fd_cnt); end
   endtask

   task automatic test_mid_reset();
      int d;
      vif.win_ready = 1'b1;
      send_pixels(0, 127, 0);
      vif.win_ready = 1'b0;
      @(negedge clk);
      tests++; if (vif.win_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre_valid: got %b, required 1", vif.win_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      tests++; if (vif.win_valid !== 1'b0) begin fails++; $display("FAIL mrst_win_valid: got %b, required 0", vif.win_valid); end
      tests++; if (vif.pix_ready !== 1'b1) begin fails++; $display("FAIL mrst_pix_ready: got %b, required 1", vif.pix_ready); end
      tests++; if (vif.data_25P !== '0) begin fails++; $display("FAIL mrst_data: got %h, required 0", vif.data_25P); end
      @(posedge clk); #1;
      rst = 1'b0;
      vif.win_ready = 1'b1;
      got_q.delete(); fd_cnt = 0;
      send_pixels(0, W*H-1, 0);
      drain();
      d = first_diff();
      tests++; if (d != -1) begin fails++; $display("FAIL mrst_sequence: got first difference at window %0d of %0d, required none", d, got_q.size()); end
      tests++; if (fd_cnt != 1) begin fails++; $display("FAIL mrst_frame_done_count: got %0d, required 1", fd_cnt); end
   endtask

   initial begin
      vif.pix_valid = 1'b0;
      vif.pix_in    = '0;
      vif.win_ready = 1'b1;
      test_reset();
      test_ramp();
      test_backpressure();
      test_gaps();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
